seg7_scan_n: RTL and testbench

//  Parametrised multiplexed 7-segment display driver. Scans NUM_DIGITS common-anode digits from a

---
 rtl/seg7_scan_n.sv | 184 ++++++++++++++++++
 tb/tb_seg7_scan_n.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_n.sv
// Multiplexed common-anode 7-segment scanner: shadow-buffered frame
// loads, per-digit dp/blank/blink, leading-zero suppression, 16-level PWM.
//
// Ports:
//   clk     system clock
//   clr     synchronous active-high reset
//   x       packed hex value, digit i = x[4i+3:4i], digit 0 rightmost
//   dp_in   per-digit decimal point, 1 = lit
//   blank   per-digit force-dark
//   blink   per-digit dark while blink phase is 1
//   lzs     suppress leading zeros (digit 0 always shown)
//   bright  PWM duty, 15 = full, 0 = 1/16
//   load    1-cycle strobe, captures x/dp_in/blank/blink into shadow
//   busy    shadow holds data not yet displayed
//   frame   1-cycle pulse at each frame boundary
//   a_to_g  segments, active low, [6]=a .. [0]=g
//   an      anodes, active low
//   dp      decimal point, active low
module seg7_scan_n #(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE_W = 19,
   parameter int BLINK_BIT  = 5
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [4*NUM_DIGITS-1:0] x,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic [NUM_DIGITS-1:0]   blink,
   input  logic                    lzs,
   input  logic [3:0]              bright,
   input  logic                    load,
   output logic                    busy,
   output logic                    frame,
   output logic [6:0]              a_to_g,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    dp
);

   localparam int N  = NUM_DIGITS;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);
   localparam logic [N-1:0]  ONE  = N'(1);

   logic [PRESCALE_W-1:0] r_pre;
   logic [IW-1:0]         r_idx;
   logic [7:0]            r_fcnt;

   logic [4*N-1:0]        r_sh_x;
   logic [N-1:0]          r_sh_dp;
   logic [N-1:0]          r_sh_blank;
   logic [N-1:0]          r_sh_blink;

   logic [4*N-1:0]        r_d_x;
   logic [N-1:0]          r_d_dp;
   logic [N-1:0]          r_d_blank;
   logic [N-1:0]          r_d_blink;

   logic                  r_busy;
   logic                  r_frame;
   logic [6:0]            r_seg;
   logic [N-1:0]          r_an;
   logic                  r_dp;

   logic                  w_tick;
   logic                  w_bound;
   logic [3:0]            w_dig;
   logic [N-1:0]          w_lz;
   logic                  w_allz;
   logic                  w_dark;
   logic                  w_on;
   logic [6:0]            w_seg_nxt;
   logic [N-1:0]          w_an_nxt;
   logic                  w_dp_nxt;
   logic                  w_unused;

   function automatic logic [6:0] f_hex(input logic [3:0] d);
      logic [6:0] v;
      v = 7'h7F;
      case (d)
         4'h0: v = 7'h01;
         4'h1: v = 7'h4F;
         4'h2: v = 7'h12;
         4'h3: v = 7'h06;
         4'h4: v = 7'h4C;
         4'h5: v = 7'h24;
         4'h6: v = 7'h20;
         4'h7: v = 7'h0F;
         4'h8: v = 7'h00;
         4'h9: v = 7'h04;
         4'hA: v = 7'h08;
         4'hB: v = 7'h60;
         4'hC: v = 7'h31;
         4'hD: v = 7'h42;
         4'hE: v = 7'h30;
         4'hF: v = 7'h38;
         default: v = 7'h7F;
      endcase
      return v;
   endfunction

   assign w_tick   = &r_pre;
   assign w_bound  = w_tick && (r_idx == LAST);
   // only the blink-phase bit of the frame counter drives logic here
   assign w_unused = ^r_fcnt;

   always_comb begin
      w_dig  = r_d_x[4*r_idx +: 4];
      // w_lz[i]: display digits i..N-1 are all zero
      w_allz = 1'b1;
      w_lz   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         w_allz  = w_allz & (r_d_x[4*i +: 4] == 4'd0);
         w_lz[i] = w_allz;
      end
      w_dark = r_d_blank[r_idx]
             | (r_d_blink[r_idx] & r_fcnt[BLINK_BIT])
             | (lzs & (r_idx != '0) & w_lz[r_idx]);
      w_on   = (r_pre[PRESCALE_W-1 -: 4] <= bright);
      w_an_nxt  = '1;
      w_seg_nxt = 7'h7F;
      w_dp_nxt  = 1'b1;
      if (!w_dark && w_on) begin
         w_an_nxt  = ~(ONE << r_idx);
         w_seg_nxt = f_hex(w_dig);
         w_dp_nxt  = ~r_d_dp[r_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_pre      <= '0;
         r_idx      <= '0;
         r_fcnt     <= '0;
         r_sh_x     <= '0;
         r_sh_dp    <= '0;
         r_sh_blank <= '0;
         r_sh_blink <= '0;
         r_d_x      <= '0;
         r_d_dp     <= '0;
         r_d_blank  <= '0;
         r_d_blink  <= '0;
         r_busy     <= 1'b0;
         r_frame    <= 1'b0;
         r_seg      <= 7'h7F;
         r_an       <= '1;
         r_dp       <= 1'b1;
      end else begin
         r_pre   <= r_pre + 1'b1;
         r_frame <= w_bound;
         if (w_tick)
            r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
         if (w_bound)
            r_fcnt <= r_fcnt + 8'd1;
         // pending shadow moves to display only between frames
         if (w_bound && r_busy) begin
            r_d_x     <= r_sh_x;
            r_d_dp    <= r_sh_dp;
            r_d_blank <= r_sh_blank;
            r_d_blink <= r_sh_blink;
         end
         // a load at the boundary keeps busy set for the new data
         if (load) begin
            r_sh_x     <= x;
            r_sh_dp    <= dp_in;
            r_sh_blank <= blank;
            r_sh_blink <= blink;
            r_busy     <= 1'b1;
         end else if (w_bound) begin
            r_busy <= 1'b0;
         end
         r_seg <= w_seg_nxt;
         r_an  <= w_an_nxt;
         r_dp  <= w_dp_nxt;
      end
   end

   assign busy   = r_busy;
   assign frame  = r_frame;
   assign a_to_g = r_seg;
   assign an     = r_an;
   assign dp     = r_dp;

endmodule

// File: tb/tb_seg7_scan_n.sv
// Directed bench for seg7_scan_n with PRESCALE_W=4, NUM_DIGITS=4,
// BLINK_BIT=0: every scan cycle of each frame is checked.
module tb_seg7_scan_n;

   logic        clk = 1'b0;
   logic        clr;
   logic [15:0] x;
   logic [3:0]  dp_in;
   logic [3:0]  blank;
   logic [3:0]  blink;
   logic        lzs;
   logic [3:0]  bright;
   logic        load;
   logic        busy;
   logic        frame;
   logic [6:0]  a_to_g;
   logic [3:0]  an;
   logic        dp;

   int n_cmp = 0;
   int n_bad = 0;
   int fno   = 0;

   seg7_scan_n #(
      .NUM_DIGITS(4),
      .PRESCALE_W(4),
      .BLINK_BIT (0)
   ) dut (
      .clk   (clk),
      .clr   (clr),
      .x     (x),
      .dp_in (dp_in),
      .blank (blank),
      .blink (blink),
      .lzs   (lzs),
      .bright(bright),
      .load  (load),
      .busy  (busy),
      .frame (frame),
      .a_to_g(a_to_g),
      .an    (an),
      .dp    (dp)
   );

   always #5 clk = ~clk;

   // Runs one 64-cycle frame. Entered so that the next negedge shows
   // slot 0, prescaler 0. Optional loads at cycles ld1/ld2.
   task automatic run_frame(
      input string       nm,
      input logic [6:0]  s0, s1, s2, s3,
      input logic [3:0]  vis, e_dp, e_blk,
      input int          ld1,
      input logic [15:0] x1,
      input int          ld2,
      input logic [15:0] x2,
      input logic        e_busy
   );
      logic [6:0] segs [4];
      segs[0] = s0;
      segs[1] = s1;
      segs[2] = s2;
      segs[3] = s3;
      for (int c = 0; c < 64; c++) begin
         int         s;
         logic       lit;
         logic [3:0] e_an;
         logic [6:0] e_seg;
         logic       e_dpv;
         logic       e_fr;
         @(negedge clk);
         s     = c / 16;
         lit   = vis[s] && !(e_blk[s] && fno[0])
               && ((c % 16) <= int'(bright));
         e_an  = lit ? ~(4'b0001 << s) : 4'hF;
         e_seg = lit ? segs[s] : 7'h7F;
         e_dpv = lit ? ~e_dp[s] : 1'b1;
         e_fr  = (c == 63);
         n_cmp++;
         if (an !== e_an || a_to_g !== e_seg || dp !== e_dpv) begin
            n_bad++;
            $display("FAIL %s c=%0d an=%b want %b seg=%h want %h dp=%b want %b",
                     nm, c, an, e_an, a_to_g, e_seg, dp, e_dpv);
         end
         n_cmp++;
         if (frame !== e_fr) begin
            n_bad++;
            $display("FAIL %s_frame c=%0d got %b want %b", nm, c, frame, e_fr);
         end
         if (ld1 >= 0 && c == ld1 + 1 && c < 63) begin
            n_cmp++;
            if (busy !== 1'b1) begin
               n_bad++;
               $display("FAIL %s_busy_set c=%0d got %b want 1", nm, c, busy);
            end
         end
         if (c == 63) begin
            n_cmp++;
            if (busy !== e_busy) begin
               n_bad++;
               $display("FAIL %s_busy_end got %b want %b", nm, busy, e_busy);
            end
         end
         load = (c == ld1) || (c == ld2);
         if (c == ld1) x = x1;
         if (c == ld2) x = x2;
      end
      fno++;
   endtask

   task automatic test_reset();
      clr    = 1'b1;
      load   = 1'b0;
      x      = 16'h0;
      dp_in  = 4'h0;
      blank  = 4'h0;
      blink  = 4'h0;
      lzs    = 1'b0;
      bright = 4'd15;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if (an !== 4'hF || a_to_g !== 7'h7F || dp !== 1'b1
             || busy !== 1'b0 || frame !== 1'b0) begin
            n_bad++;
            $display("FAIL reset an=%b seg=%h dp=%b busy=%b frame=%b want 1111/7f/1/0/0",
                     an, a_to_g, dp, busy, frame);
         end
      end
      clr = 1'b0;
      fno = 0;
      run_frame("scan0", 7'h01, 7'h01, 7'h01, 7'h01,
                4'hF, 4'h0, 4'h0, -1, 16'h0, -1, 16'h0, 1'b0);
   endtask

   task automatic test_load();
      run_frame("load1234", 7'h01, 7'h01, 7'h01, 7'h01,
                4'hF, 4'h0, 4'h0, 0, 16'h1234, -1, 16'h0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_frame("show1234", 7'h4C, 7'h06, 7'h12, 7'h4F,
                4'hF, 4'h0, 4'h0, 10, 16'hABCD, 40, 16'h5678, 1'b0);
      dp_in = 4'b0101;
      run_frame("show5678", 7'h00, 7'h0F, 7'h20, 7'h24,
                4'hF, 4'h0, 4'h0, 10, 16'h4321, 62, 16'hFEDC, 1'b1);
      run_frame("show4321", 7'h4F, 7'h12, 7'h06, 7'h4C,
                4'hF, 4'b0101, 4'h0, -1, 16'h0, -1, 16'h0, 1'b0);
   endtask

   task automatic test_lzs();
      dp_in = 4'h0;
      run_frame("showFEDC", 7'h31, 7'h42, 7'h30, 7'h38,
                4'hF, 4'b0101, 4'h0, 5, 16'h0050, -1, 16'h0, 1'b0);
      lzs = 1'b1;
      run_frame("lzs0050", 7'h01, 7'h24, 7'h7F, 7'h7F,
                4'b0011, 4'h0, 4'h0, 5, 16'h0000, -1, 16'h0, 1'b0);
      run_frame("lzs0000", 7'h01, 7'h7F, 7'h7F, 7'h7F,
                4'b0001, 4'h0, 4'h0, -1, 16'h0, -1, 16'h0, 1'b0);
      lzs = 1'b0;
   endtask

   task automatic test_pwm_blink();
      bright = 4'd0;
      blank  = 4'b0100;
      blink  = 4'b0001;
      run_frame("pwm0", 7'h01, 7'h01, 7'h01, 7'h01,
                4'hF, 4'h0, 4'h0, 5, 16'h0000, -1, 16'h0, 1'b0);
      bright = 4'd15;
      run_frame("blink_odd", 7'h01, 7'h01, 7'h7F, 7'h01,
                4'b1011, 4'h0, 4'b0001, -1, 16'h0, -1, 16'h0, 1'b0);
      run_frame("blink_even", 7'h01, 7'h01, 7'h7F, 7'h01,
                4'b1011, 4'h0, 4'b0001, -1, 16'h0, -1, 16'h0, 1'b0);
      blank = 4'h0;
      blink = 4'h0;
   endtask

   task automatic test_clr_mid();
      for (int c = 0; c <= 40; c++) begin
         @(negedge clk);
         load = (c == 5);
         if (c == 5) x = 16'h9999;
         if (c == 40) begin
            n_cmp++;
            if (busy !== 1'b1) begin
               n_bad++;
               $display("FAIL clr_pre_busy got %b want 1", busy);
            end
            clr  = 1'b1;
            load = 1'b1;
            x    = 16'h7777;
         end
      end
      @(negedge clk);
      n_cmp++;
      if (an !== 4'hF || a_to_g !== 7'h7F || dp !== 1'b1
          || busy !== 1'b0 || frame !== 1'b0) begin
         n_bad++;
         $display("FAIL clr_mid an=%b seg=%h dp=%b busy=%b frame=%b want 1111/7f/1/0/0",
                  an, a_to_g, dp, busy, frame);
      end
      clr  = 1'b0;
      load = 1'b0;
      fno  = 0;
      run_frame("restart", 7'h01, 7'h01, 7'h01, 7'h01,
                4'hF, 4'h0, 4'h0, -1, 16'h0, -1, 16'h0, 1'b0);
      run_frame("restart2", 7'h01, 7'h01, 7'h01, 7'h01,
                4'hF, 4'h0, 4'h0, -1, 16'h0, -1, 16'h0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_load();
      test_back_to_back();
      test_lzs();
      test_pwm_blink();
      test_clr_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
